fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the pipelined MIPS32 core. Each cycle it drives the IF stage's master PC mux select, PC-register enable and PC clear, and the IF/ID and ID/EX enable/flush controls. It arbitrates between EX-stage redirects (taken branch, `jr`), ID-stage jumps, load-use stalls from the hazard unit, and instruction-memory wait states. It also keeps stall and flush event counters and raises a sticky fault when a fetch never completes.

---
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_fetch_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates redirects, load-use stalls and imem wait
// states into PC-mux / pipeline-register controls, with event counters and a fetch timeout.
module fetch_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             branch_taken_EX,
  input  logic             jr_EX,
  input  logic             jump_ID,
  input  logic             ld_use_stall,
  input  logic             imem_ready,
  output logic [1:0]       PCsrc,
  output logic             en_IF,
  output logic             clr_PC,
  output logic             en_IFID,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             fetch_fault,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  localparam int WC_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    WAIT  = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0]  cnt_flush_q, cnt_flush_d;

  // Wait-state bookkeeping driven by imem_ready alone; shared by the stall
  // and not-ready rules so a stall never hides a timing-out fetch.
  state_t            mem_state;
  logic [WC_W-1:0]   mem_cnt;

  always_comb begin
    mem_state = RUN;
    mem_cnt   = '0;
    if (!imem_ready) begin
      mem_cnt   = wait_cnt_q + WC_W'(1);
      mem_state = (wait_cnt_q == WC_W'(WAIT_MAX - 1)) ? FAULT : WAIT;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cnt_stall_d = cnt_stall_q;
    cnt_flush_d = cnt_flush_q;
    PCsrc       = 2'b00;
    en_IF       = 1'b1;
    clr_PC      = 1'b0;
    en_IFID     = 1'b1;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;

    if (clr || state_q == BOOT) begin
      en_IF      = 1'b0;
      clr_PC     = 1'b1;
      en_IFID    = 1'b0;
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
      state_d    = RUN;
      wait_cnt_d = '0;
      if (clr) begin
        state_d     = BOOT;
        cnt_stall_d = '0;
        cnt_flush_d = '0;
      end
    end else if (state_q == FAULT) begin
      en_IF      = 1'b0;
      flush_IFID = 1'b1;
    end else if (branch_taken_EX || jr_EX) begin
      PCsrc       = branch_taken_EX ? 2'b11 : 2'b10;
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      cnt_flush_d = cnt_flush_q + CNT_W'(1);
      wait_cnt_d  = '0;
      state_d     = RUN;
    end else if (ld_use_stall) begin
      // Hold PC and IF/ID; a jump in ID simply re-presents next cycle.
      en_IF       = 1'b0;
      en_IFID     = 1'b0;
      flush_IDEX  = 1'b1;
      cnt_stall_d = cnt_stall_q + CNT_W'(1);
      wait_cnt_d  = mem_cnt;
      state_d     = mem_state;
    end else if (jump_ID) begin
      PCsrc       = 2'b01;
      flush_IFID  = 1'b1;
      cnt_flush_d = cnt_flush_q + CNT_W'(1);
      wait_cnt_d  = '0;
      state_d     = RUN;
    end else if (!imem_ready) begin
      en_IF      = 1'b0;
      flush_IFID = 1'b1;
      wait_cnt_d = mem_cnt;
      state_d    = mem_state;
    end else begin
      wait_cnt_d = '0;
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    cnt_stall_q <= cnt_stall_d;
    cnt_flush_q <= cnt_flush_d;
  end

  assign state       = state_q;
  assign fetch_fault = (state_q == FAULT);
  assign cnt_stall   = cnt_stall_q;
  assign cnt_flush   = cnt_flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle-level behavioural model is compared
// against the DUT every cycle, plus hand-computed checks at key points.
module tb_fetch_ctrl;

  localparam int WAIT_MAX = 16;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             clr, branch_taken_EX, jr_EX, jump_ID, ld_use_stall, imem_ready;
  logic [1:0]       PCsrc, state;
  logic             en_IF, clr_PC, en_IFID, flush_IFID, flush_IDEX, fetch_fault;
  logic [CNT_W-1:0] cnt_stall, cnt_flush;

  int total  = 0;
  int passed = 0;

  fetch_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr), .branch_taken_EX(branch_taken_EX), .jr_EX(jr_EX),
    .jump_ID(jump_ID), .ld_use_stall(ld_use_stall), .imem_ready(imem_ready),
    .PCsrc(PCsrc), .en_IF(en_IF), .clr_PC(clr_PC), .en_IFID(en_IFID),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .fetch_fault(fetch_fault),
    .state(state), .cnt_stall(cnt_stall), .cnt_flush(cnt_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask

  // Model: which phase the sequencer is in, how long the current fetch has
  // been pending, and the two event counts.
  bit model_on = 0;
  bit booting  = 0;
  bit faulted  = 0;
  int waitn    = 0;
  int n_stall  = 0;
  int n_flush  = 0;

  always @(posedge clk) begin
    bit b, f; int w, s, fl;
    b = booting; f = faulted; w = waitn; s = n_stall; fl = n_flush;
    if (clr === 1'b1) begin
      b = 1; f = 0; w = 0; s = 0; fl = 0;
      model_on <= 1;
    end else if (b) begin
      b = 0;
    end else if (!f) begin
      if (branch_taken_EX || jr_EX) begin
        fl = (fl + 1) % 16; w = 0;
      end else if (ld_use_stall || !jump_ID) begin
        if (ld_use_stall) s = (s + 1) % 16;
        if (!imem_ready) begin
          if (w == WAIT_MAX - 1) f = 1;
          else w = w + 1;
        end else w = 0;
      end else begin
        fl = (fl + 1) % 16; w = 0;
      end
    end
    booting <= b; faulted <= f; waitn <= w; n_stall <= s; n_flush <= fl;
  end

  always @(negedge clk) begin
    int e_pc, e_st; bit e_if, e_cpc, e_ifid, e_fifid, e_fidex;
    if (model_on) begin
      e_pc = 0; e_if = 1; e_cpc = 0; e_ifid = 1; e_fifid = 0; e_fidex = 0;
      e_st = booting ? 0 : faulted ? 3 : (waitn > 0) ? 2 : 1;
      if (clr || booting) begin
        e_if = 0; e_cpc = 1; e_ifid = 0; e_fifid = 1; e_fidex = 1;
      end else if (faulted) begin
        e_if = 0; e_fifid = 1;
      end else if (branch_taken_EX || jr_EX) begin
        e_pc = branch_taken_EX ? 3 : 2; e_fifid = 1; e_fidex = 1;
      end else if (ld_use_stall) begin
        e_if = 0; e_ifid = 0; e_fidex = 1;
      end else if (jump_ID) begin
        e_pc = 1; e_fifid = 1;
      end else if (!imem_ready) begin
        e_if = 0; e_fifid = 1;
      end
      chk("PCsrc", 32'(PCsrc), 32'(e_pc));
      chk("en_IF", 32'(en_IF), 32'(e_if));
      chk("clr_PC", 32'(clr_PC), 32'(e_cpc));
      chk("en_IFID", 32'(en_IFID), 32'(e_ifid));
      chk("flush_IFID", 32'(flush_IFID), 32'(e_fifid));
      chk("flush_IDEX", 32'(flush_IDEX), 32'(e_fidex));
      chk("state", 32'(state), 32'(e_st));
      chk("cnt_stall", 32'(cnt_stall), 32'(n_stall));
      chk("cnt_flush", 32'(cnt_flush), 32'(n_flush));
      if (!clr) chk("fetch_fault", 32'(fetch_fault), 32'(faulted));
    end
  end

  // Inputs change 1 time unit after the rising edge; literal checks run after the falling edge.
  task automatic step(input logic c, b, jr, jp, ld, rdy);
    @(posedge clk); #1;
    clr = c; branch_taken_EX = b; jr_EX = jr; jump_ID = jp; ld_use_stall = ld; imem_ready = rdy;
    @(negedge clk); #1;
  endtask

  initial begin
    clr = 1; branch_taken_EX = 0; jr_EX = 0; jump_ID = 0; ld_use_stall = 0; imem_ready = 1;
    // reset
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 1);
    chk("lit_rst_clrPC", 32'(clr_PC), 1);
    chk("lit_rst_state", 32'(state), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_boot_enIF", 32'(en_IF), 0);
    chk("lit_boot_state", 32'(state), 0);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_run_state", 32'(state), 1);
    chk("lit_run_enIF", 32'(en_IF), 1);
    chk("lit_run_cnt", 32'({cnt_stall, cnt_flush}), 0);
    // all requests at once
    step(0, 1, 1, 1, 1, 1);
    chk("lit_all_PCsrc", 32'(PCsrc), 3);
    chk("lit_all_flush", 32'({flush_IFID, flush_IDEX, en_IF}), 3'b111);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_all_cflush", 32'(cnt_flush), 1);
    chk("lit_all_cstall", 32'(cnt_stall), 0);
    // jr alone
    step(0, 0, 1, 0, 0, 1);
    chk("lit_jr_PCsrc", 32'(PCsrc), 2);
    // stall defers jump
    step(0, 0, 0, 1, 1, 1);
    chk("lit_stj_en", 32'({en_IF, en_IFID, flush_IDEX}), 3'b001);
    step(0, 0, 0, 1, 0, 1);
    chk("lit_stj_PCsrc", 32'(PCsrc), 1);
    chk("lit_stj_fIFID", 32'(flush_IFID), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_stj_cstall", 32'(cnt_stall), 1);
    chk("lit_stj_cflush", 32'(cnt_flush), 3);
    // memory wait
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("lit_mw_enIF", 32'({en_IF, flush_IFID}), 2'b01);
      if (i > 0) chk("lit_mw_state", 32'(state), 2);
    end
    step(0, 0, 0, 0, 0, 1);
    chk("lit_mw_rdy_enIF", 32'(en_IF), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_mw_back_state", 32'(state), 1);
    // stall while not ready, then jump abandons a pending fetch
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_stw_state", 32'(state), 2);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("lit_jw_PCsrc", 32'(PCsrc), 1);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_jw_state", 32'(state), 1);
    // fault
    for (int i = 0; i < WAIT_MAX; i++) step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("lit_flt_state", 32'(state), 3);
    chk("lit_flt_fault", 32'(fetch_fault), 1);
    chk("lit_flt_enIF", 32'(en_IF), 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_flt_clr_state", 32'(state), 0);
    chk("lit_flt_clr_fault", 32'(fetch_fault), 0);
    // counter wrap
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("lit_wrap_cflush", 32'(cnt_flush), 1);
    step(0, 0, 0, 0, 0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
